// File: rtl/hsync_sequencer_pkg.sv
// Shared video timing definitions: phase encoding and default segment lengths.
package hsync_sequencer_pkg;

  // Line phase encoding, also driven out on the phase port.
  localparam logic [1:0] PH_SYNC   = 2'd0;
  localparam logic [1:0] PH_BACK   = 2'd1;
  localparam logic [1:0] PH_ACTIVE = 2'd2;
  localparam logic [1:0] PH_FRONT  = 2'd3;

  // Default horizontal timing, in enabled cycles.
  localparam int unsigned DEF_WIDTH      = 8;
  localparam int unsigned DEF_SYNC_LEN   = 16;
  localparam int unsigned DEF_BACK_LEN   = 12;
  localparam int unsigned DEF_ACTIVE_LEN = 128;
  localparam int unsigned DEF_FRONT_LEN  = 12;

endpackage

// File: rtl/hsync_sequencer_load_down_counter.sv
// Loadable down-counter that stops at zero; load wins over the count enable.
module load_down_counter #(
  parameter int unsigned     WIDTH       = 8,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  output logic [WIDTH-1:0] count,
  output logic             zero
);

  logic [WIDTH-1:0] count_q;

  // Load takes priority; otherwise decrement while enabled and non-zero.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count_q <= RESET_VALUE;
    end else if (load) begin
      count_q <= load_value;
    end else if (enable && (count_q != '0)) begin
      count_q <= count_q - WIDTH'(1);
    end
  end

  assign count = count_q;
  assign zero  = (count_q == '0);

endmodule

// File: rtl/hsync_sequencer.sv
// Horizontal timing sequencer: steps sync, back porch, active and front porch
// using a loadable down-counter, and produces sync, enable, pixel index and
// end-of-line outputs.
module hsync_sequencer
  import hsync_sequencer_pkg::*;
#(
  parameter int unsigned WIDTH      = DEF_WIDTH,
  parameter int unsigned SYNC_LEN   = DEF_SYNC_LEN,
  parameter int unsigned BACK_LEN   = DEF_BACK_LEN,
  parameter int unsigned ACTIVE_LEN = DEF_ACTIVE_LEN,
  parameter int unsigned FRONT_LEN  = DEF_FRONT_LEN
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic             restart,
  output logic             hs_n,
  output logic             active,
  output logic [WIDTH-1:0] pix_x,
  output logic             line_end,
  output logic [1:0]       phase
);

  // Counter reload values: the counter holds remaining cycles minus one.
  localparam logic [WIDTH-1:0] SyncM1   = WIDTH'(SYNC_LEN - 1);
  localparam logic [WIDTH-1:0] BackM1   = WIDTH'(BACK_LEN - 1);
  localparam logic [WIDTH-1:0] ActiveM1 = WIDTH'(ACTIVE_LEN - 1);
  localparam logic [WIDTH-1:0] FrontM1  = WIDTH'(FRONT_LEN - 1);

  logic [1:0]       phase_q, phase_d;
  logic [WIDTH-1:0] pix_x_q, pix_x_d;
  logic             line_end_q, line_end_d;

  logic [WIDTH-1:0] cnt;
  logic             cnt_zero;
  logic             cnt_load;
  logic [WIDTH-1:0] cnt_load_value;

  load_down_counter #(
    .WIDTH       (WIDTH),
    .RESET_VALUE (SyncM1)
  ) u_cnt (
    .clk        (clk),
    .reset      (reset),
    .enable     (enable),
    .load       (cnt_load),
    .load_value (cnt_load_value),
    .count      (cnt),
    .zero       (cnt_zero)
  );

  // Next-state for the phase FSM, pixel index and end-of-line pulse.
  always_comb begin
    phase_d        = phase_q;
    pix_x_d        = pix_x_q;
    line_end_d     = 1'b0;
    cnt_load       = 1'b0;
    cnt_load_value = SyncM1;
    if (restart) begin
      phase_d        = PH_SYNC;
      pix_x_d        = '0;
      cnt_load       = 1'b1;
      cnt_load_value = SyncM1;
    end else if (enable) begin
      if (cnt_zero) begin
        cnt_load = 1'b1;
        unique case (phase_q)
          PH_SYNC: begin
            phase_d        = PH_BACK;
            cnt_load_value = BackM1;
          end
          PH_BACK: begin
            phase_d        = PH_ACTIVE;
            pix_x_d        = '0;
            cnt_load_value = ActiveM1;
          end
          PH_ACTIVE: begin
            phase_d        = PH_FRONT;
            pix_x_d        = '0;
            cnt_load_value = FrontM1;
          end
          PH_FRONT: begin
            phase_d        = PH_SYNC;
            line_end_d     = 1'b1;
            cnt_load_value = SyncM1;
          end
        endcase
      end else if (phase_q == PH_ACTIVE) begin
        pix_x_d = pix_x_q + WIDTH'(1);
      end
    end
  end

  // State registers; line_end clears on every edge it is not re-armed.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      phase_q    <= PH_SYNC;
      pix_x_q    <= '0;
      line_end_q <= 1'b0;
    end else begin
      phase_q    <= phase_d;
      pix_x_q    <= pix_x_d;
      line_end_q <= line_end_d;
    end
  end

  // Outputs decode the phase register directly; no input reaches an output.
  always_comb begin
    phase    = phase_q;
    hs_n     = (phase_q != PH_SYNC);
    active   = (phase_q == PH_ACTIVE);
    pix_x    = pix_x_q;
    line_end = line_end_q;
  end

endmodule

// File: tb/tb_hsync_sequencer.sv
// Directed bench for hsync_sequencer: a default-length instance checked every
// edge against a line-position model, plus an all-lengths-1 instance.
module tb_hsync_sequencer;

  localparam int LINE = 168;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       enable = 1'b0;
  logic       restart = 1'b0;
  logic       hs_n, active, line_end;
  logic [7:0] pix_x;
  logic [1:0] phase;

  logic       reset1 = 1'b0;
  logic       enable1 = 1'b0;
  logic       restart1 = 1'b0;
  logic       hs_n1, active1, line_end1;
  logic [7:0] pix_x1;
  logic [1:0] phase1;

  int compared = 0;
  int mismatched = 0;
  int pos = 0;      // enabled edges since line start, modulo LINE
  int le_exp = 0;

  always #5 clk = ~clk;

  hsync_sequencer dut (
    .clk      (clk),
    .reset    (reset),
    .enable   (enable),
    .restart  (restart),
    .hs_n     (hs_n),
    .active   (active),
    .pix_x    (pix_x),
    .line_end (line_end),
    .phase    (phase)
  );

  hsync_sequencer #(
    .WIDTH      (8),
    .SYNC_LEN   (1),
    .BACK_LEN   (1),
    .ACTIVE_LEN (1),
    .FRONT_LEN  (1)
  ) dut1 (
    .clk      (clk),
    .reset    (reset1),
    .enable   (enable1),
    .restart  (restart1),
    .hs_n     (hs_n1),
    .active   (active1),
    .pix_x    (pix_x1),
    .line_end (line_end1),
    .phase    (phase1)
  );

  task automatic check(input string tag, input int obs, input int exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic int exp_phase(input int p);
    if (p < 16) return 0;
    if (p < 28) return 1;
    if (p < 156) return 2;
    return 3;
  endfunction

  task automatic check_main(input string tag);
    int ph;
    ph = exp_phase(pos);
    check({tag, ".phase"}, int'(phase), ph);
    check({tag, ".hs_n"}, int'(hs_n), (ph != 0) ? 1 : 0);
    check({tag, ".active"}, int'(active), (ph == 2) ? 1 : 0);
    check({tag, ".pix_x"}, int'(pix_x), (ph == 2) ? pos - 28 : 0);
    check({tag, ".line_end"}, int'(line_end), le_exp);
  endtask

  // One clock edge with the given inputs; model advances, then outputs checked.
  task automatic step(input string tag, input logic en, input logic rs);
    enable  = en;
    restart = rs;
    @(posedge clk);
    if (rs) begin
      pos = 0;
      le_exp = 0;
    end else if (en) begin
      pos = (pos + 1) % LINE;
      le_exp = (pos == 0) ? 1 : 0;
    end else begin
      le_exp = 0;
    end
    #1;
    check_main(tag);
  endtask

  initial begin
    // Reset values while reset is held low.
    #1;
    check_main("reset");

    @(negedge clk);
    reset  = 1'b1;
    reset1 = 1'b1;

    // Two full lines with continuous enable.
    for (int i = 0; i < 2 * LINE; i++) step("cont", 1'b1, 1'b0);

    // Alternate-cycle enable doubles every phase.
    for (int i = 0; i < 4 * LINE; i++) step("alt", (i % 2) == 1, 1'b0);

    // Restart in the middle of the active segment at pix_x = 50.
    for (int i = 0; i < 2 * LINE && pos != 78; i++) step("to_px50", 1'b1, 1'b0);
    check("px50_reached", int'(pix_x), 50);
    step("restart_px50", 1'b1, 1'b1);
    for (int i = 0; i < LINE + 2; i++) step("after_restart", 1'b1, 1'b0);

    // Asynchronous reset mid-active: outputs must change before any edge.
    for (int i = 0; i < 2 * LINE && pos != 60; i++) step("to_mid", 1'b1, 1'b0);
    #2;
    reset = 1'b0;
    #1;
    pos = 0;
    le_exp = 0;
    check_main("async_reset");
    @(negedge clk);
    reset = 1'b1;
    for (int i = 0; i < LINE + 2; i++) step("after_reset", 1'b1, 1'b0);

    // Restart together with enable on the FRONT terminal edge.
    for (int i = 0; i < 2 * LINE && pos != LINE - 1; i++) step("to_front_end", 1'b1, 1'b0);
    check("front_end_phase", int'(phase), 3);
    step("restart_front", 1'b1, 1'b1);
    for (int i = 0; i < 20; i++) step("after_front_restart", 1'b1, 1'b0);

    // All-lengths-1 instance: phase advances every edge, line_end every 4th.
    enable = 1'b0;
    enable1 = 1'b1;
    for (int k = 1; k <= 12; k++) begin
      @(posedge clk);
      #1;
      check("len1.phase", int'(phase1), k % 4);
      check("len1.line_end", int'(line_end1), (k % 4 == 0) ? 1 : 0);
      check("len1.pix_x", int'(pix_x1), 0);
      check("len1.active", int'(active1), (k % 4 == 2) ? 1 : 0);
    end
    enable1 = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/hsync_sequencer.md
# hsync_sequencer

Horizontal timing sequencer for the 6847 replacement video path. A loadable down-counter steps through four line phases: sync, back porch, active and front porch. From these phases the block produces a registered sync strobe, a display-enable, an up-counting active-pixel index and an end-of-line pulse. It consumes a clock enable in the same way the existing free-running counters do. It counts segment lengths downward rather than raw edges upward, and it drives the pixel/row counters and the sync outputs downstream.

## Interface
- `WIDTH`, 8: width of the segment counter and of `pix_x`.
- `SYNC_LEN`, 16: sync segment length, in enabled cycles.
- `BACK_LEN`, 12: back-porch length.
- `ACTIVE_LEN`, 128: active segment length; must be ≤ 2^WIDTH.
- `FRONT_LEN`, 12: front-porch length.
- All lengths are in the range 1..2^WIDTH. Any other value is a configuration error.

- `clk`  in  1  single clock; all state changes occur on the rising edge only.
- `reset`  in  1  asynchronous, active-low reset.
- `enable`  in  1  clock enable; state advances only when high.
- `restart`  in  1  synchronous line restart; takes priority over `enable`.
- `hs_n`  out  1  sync strobe, low during SYNC.
- `active`  out  1  high during ACTIVE.
- `pix_x`  out  WIDTH  active-pixel index; 0 outside ACTIVE.
- `line_end`  out  1  one-cycle pulse when a full line completes.
- `phase`  out  2  current phase: SYNC=0, BACK=1, ACTIVE=2, FRONT=3.

## Operation
- Internal state:
  - phase register;
  - down-counter `cnt` of WIDTH bits, holding the remaining cycles in the phase minus one.
- Reset (`reset`=0, asynchronous), all values:
  - phase=SYNC, `cnt`=SYNC_LEN-1;
  - `hs_n`=0, `active`=0, `pix_x`=0, `line_end`=0.
- Rising edge with `restart`=1, regardless of `enable`:
  - same values as reset;
  - a `line_end` that is high is cleared.
- Rising edge with `enable`=1 and `cnt`≠0: `cnt` decrements by 1.
  - In ACTIVE, `pix_x` also increments by 1.
- Rising edge with `enable`=1 and `cnt`=0: advance to the next phase and load `cnt` with that phase's length minus 1. Transitions:
  - SYNC→BACK;
  - BACK→ACTIVE (`pix_x`=0, `active`=1);
  - ACTIVE→FRONT (`pix_x`=0, `active`=0);
  - FRONT→SYNC (`line_end`=1).
- `line_end` is set only on the FRONT→SYNC transition. It clears on the next rising edge.
- Rising edge with `enable`=0:
  - all state holds;
  - `line_end` still clears, so it is strictly one clock wide.
- `hs_n`, `active` and `phase` are registered, or are a direct decode of the phase register. There is no combinational path from any input to any output.
- Arithmetic:
  - `cnt` never underflows, because a reload happens at 0;
  - `pix_x` peaks at ACTIVE_LEN-1 and never wraps inside a line.
- Length of 1: the phase lasts exactly one enabled cycle (reload straight to 0).

## Timing
- With every cycle enabled, each phase lasts exactly its length in clocks.
- Line period = SYNC_LEN + BACK_LEN + ACTIVE_LEN + FRONT_LEN enabled cycles (168 at defaults).
- From reset release, at default lengths and continuous `enable`, counting rising edges from 1:
  - edge 16: phase→BACK, `hs_n`=1;
  - edge 28: ACTIVE, `pix_x`=0;
  - edge 155: `pix_x`=127;
  - edge 156: FRONT, `active`=0;
  - edge 168: SYNC, `hs_n`=0, `line_end`=1;
  - edge 169: `line_end`=0.
- Reset does not produce `line_end`; the first pulse comes at the end of the first full line.
- Reset asserted mid-line: outputs take reset values immediately, without waiting for a clock edge.
- `restart` and `enable` on the same edge: `restart` wins, and no phase advance or `line_end` occurs.
- Output latency from the causing edge is 0 cycles: outputs are valid after the same edge.

## Structure
- A shared video package holds:
  - phase encoding constants (SYNC=0, BACK=1, ACTIVE=2, FRONT=3);
  - default segment lengths.
- One sub-module, `load_down_counter`:
  - parameter WIDTH;
  - ports `clk`, `reset`, `enable`, `load`, `load_value`, `count`, `zero`.
- The sequencer wraps `load_down_counter` with the phase FSM, the `pix_x` counter and the output registers.

## Test plan
- Reset, then continuous `enable` -> `hs_n` low for 16 clocks, `active` high for exactly 128 clocks with `pix_x` 0..127, `line_end` a single pulse at edge 168, repeating every 168 clocks.
- `enable` toggled on alternate clocks -> every phase duration doubles exactly (line = 336 clocks); `line_end` is still one clock wide.
- `restart` pulsed at `pix_x`=50 -> next edge gives phase=SYNC, `pix_x`=0, `active`=0, no `line_end`; full-line timing resumes from that edge.
- `reset` asserted asynchronously mid-ACTIVE -> outputs immediately take reset values; after release, first `line_end` comes at edge 168.
- All lengths set to 1 -> phases cycle 0,1,2,3 every clock; `line_end` on every 4th edge; `pix_x` stays 0.
- `restart` and `enable` high on the FRONT `cnt`=0 edge -> no `line_end`; phase=SYNC with `cnt`=SYNC_LEN-1.
